// File: rtl/lane_controller_if.sv
// Player-input bundle between the button/vsync sources and the lane controller,
// carrying the head layer offset and lane status back out.
interface lane_controller_if;
  logic               btn_l;
  logic               btn_r;
  logic               vsync;
  logic               enable;
  logic signed [11:0] hoffset;
  logic [1:0]         lane;
  logic               moving;

  modport master (
    output btn_l, btn_r, vsync, enable,
    input  hoffset, lane, moving
  );

  modport slave (
    input  btn_l, btn_r, vsync, enable,
    output hoffset, lane, moving
  );
endinterface

// File: rtl/lane_controller.sv
// Debounced left/right lane selection for the head sprite, with the horizontal
// offset slewed toward the selected lane by at most STEP pixels per video frame.
module lane_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LANE_SPACING    = 100,
  parameter int STEP            = 20
) (
  input logic              clk,
  input logic              rst,
  lane_controller_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [11:0]   SPACING12 = 12'(LANE_SPACING);
  localparam logic signed [11:0]   STEP12    = 12'(STEP);
  localparam logic signed [12:0]   STEP13    = 13'(STEP);

  typedef enum logic {IDLE, SLIDE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         btn_raw, btn_meta, btn_sync, btn_deb, btn_deb_prev, press;
  logic [CW-1:0]      deb_cnt [2];
  logic               vs_meta, vs_sync, vs_prev, tick;
  logic [1:0]         lane_q;
  logic signed [11:0] hoffset_q, hoffset_d, target, slewed;
  logic signed [12:0] diff;

  // Bit 0 is the left button, bit 1 the right button throughout.
  assign btn_raw = {bus.btn_r, bus.btn_l};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      vs_meta  <= bus.vsync;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatched samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_deb      <= '0;
      btn_deb_prev <= '0;
      deb_cnt[0]   <= '0;
      deb_cnt[1]   <= '0;
    end else begin
      btn_deb_prev <= btn_deb;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          btn_deb[i] <= btn_sync[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = btn_deb & ~btn_deb_prev;
  assign tick  = vs_sync & ~vs_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd1;
    end else if (bus.enable && press[0] && !press[1] && lane_q != 2'd0) begin
      lane_q <= lane_q - 2'd1;
    end else if (bus.enable && press[1] && !press[0] && lane_q != 2'd2) begin
      lane_q <= lane_q + 2'd1;
    end
  end

  always_comb begin
    target = '0;
    case (lane_q)
      2'd0:    target = -SPACING12;
      2'd2:    target = SPACING12;
      default: target = '0;
    endcase
  end

  // Difference is taken one bit wider so the largest lane jump cannot wrap.
  assign diff = {target[11], target} - {hoffset_q[11], hoffset_q};

  always_comb begin
    slewed = target;
    if (diff > STEP13) begin
      slewed = hoffset_q + STEP12;
    end else if (diff < -STEP13) begin
      slewed = hoffset_q - STEP12;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hoffset_q <= '0;
    end else begin
      state_q   <= state_d;
      hoffset_q <= hoffset_d;
    end
  end

  // A lane reverted before any tick still waits for a tick, which then moves nothing.
  always_comb begin
    state_d   = state_q;
    hoffset_d = hoffset_q;
    case (state_q)
      IDLE: begin
        if (hoffset_q != target) begin
          state_d = SLIDE;
        end
      end
      SLIDE: begin
        if (tick) begin
          hoffset_d = slewed;
          if (slewed == target) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.hoffset = hoffset_q;
  assign bus.lane    = lane_q;
  assign bus.moving  = (state_q == SLIDE);

endmodule

// File: tb/tb_lane_controller.sv
// Randomized frame-by-frame bench for lane_controller: a lane/offset reference
// model feeds expected steps to a queue that an independent monitor consumes.
module tb_lane_controller;

  localparam int DEB   = 4;
  localparam int SPC   = 100;
  localparam int STP   = 20;
  localparam int FRAME = 40;

  typedef enum int {A_IDLE, A_R, A_L, A_BOTH, A_BOUNCE, A_DIS_R, A_DIS_L} act_t;
  typedef struct {
    int hoff;
    int moving;
  } hexp_t;

  logic clk = 1'b0;
  logic rst;

  lane_controller_if bus();

  lane_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .LANE_SPACING(SPC),
    .STEP(STP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  hexp_t hq[$];
  int    lq[$];
  int    m_lane = 1;
  int    m_hoff = 0;
  bit    mon_on = 1'b1;
  int    prev_h, prev_l;
  hexp_t mon_e;
  int    mon_l;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int target_of(input int l);
    return (l - 1) * SPC;
  endfunction

  // Each frame the head moves toward its lane by the gap, clamped to +/-STEP.
  function automatic void model_tick();
    int t, gap;
    t   = target_of(m_lane);
    gap = t - m_hoff;
    if (gap != 0) begin
      if (gap > STP) gap = STP;
      if (gap < -STP) gap = -STP;
      m_hoff = m_hoff + gap;
      hq.push_back('{m_hoff, int'(m_hoff != t)});
    end
  endfunction

  function automatic void model_action(input act_t a);
    if (a == A_R && m_lane < 2) begin
      m_lane++;
      lq.push_back(m_lane);
    end else if (a == A_L && m_lane > 0) begin
      m_lane--;
      lq.push_back(m_lane);
    end
  endfunction

  // Monitor: every observed change of offset or lane must match the next expectation.
  always @(negedge clk) begin
    if (rst || !mon_on) begin
      prev_h = bus.hoffset;
      prev_l = bus.lane;
    end else begin
      if (int'(bus.hoffset) != prev_h) begin
        if (hq.size() == 0) begin
          checkOutput("unexpected hoffset step", bus.hoffset, prev_h);
        end else begin
          mon_e = hq.pop_front();
          checkOutput("hoffset step", bus.hoffset, mon_e.hoff);
          checkOutput("moving after step", bus.moving, mon_e.moving);
        end
        prev_h = bus.hoffset;
      end
      if (int'(bus.lane) != prev_l) begin
        if (lq.size() == 0) begin
          checkOutput("unexpected lane change", bus.lane, prev_l);
        end else begin
          mon_l = lq.pop_front();
          checkOutput("lane change", bus.lane, mon_l);
        end
        prev_l = bus.lane;
      end
    end
  end

  task automatic applyStimulus(input act_t a);
    bit in_press;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      bus.vsync = (c < 2);
      if (c == 0) model_tick();
      if (c == 8) model_action(a);
      in_press   = (c >= 8 && c < 18);
      bus.btn_r  = in_press && (a == A_R || a == A_BOTH || a == A_DIS_R);
      bus.btn_l  = (in_press && (a == A_L || a == A_BOTH || a == A_DIS_L)) ||
                   (a == A_BOUNCE && c >= 8 && c < 38 && ((c - 8) / 2) % 2 == 0);
      bus.enable = !((a == A_DIS_R || a == A_DIS_L) && c >= 4 && c < 34);
      if (c == 35) begin
        checkOutput("frame lane", bus.lane, m_lane);
        checkOutput("frame moving", bus.moving, int'(m_hoff != target_of(m_lane)));
      end
    end
  endtask

  task automatic checkDrained();
    checkOutput("pending hoffset steps", hq.size(), 0);
    checkOutput("pending lane changes", lq.size(), 0);
    checkOutput("settled hoffset", bus.hoffset, m_hoff);
    checkOutput("settled lane", bus.lane, m_lane);
  endtask

  initial begin
    act_t directed[] = '{A_R, A_IDLE, A_IDLE, A_IDLE, A_IDLE, A_IDLE, A_IDLE,
                         A_BOUNCE, A_IDLE, A_R, A_R, A_R, A_IDLE,
                         A_L, A_L, A_IDLE, A_L, A_IDLE, A_IDLE, A_R, A_IDLE,
                         A_DIS_R, A_DIS_L, A_BOTH, A_IDLE};
    rst        = 1'b1;
    bus.btn_l  = 1'b0;
    bus.btn_r  = 1'b0;
    bus.vsync  = 1'b0;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset hoffset", bus.hoffset, 0);
    checkOutput("reset lane", bus.lane, 1);
    checkOutput("reset moving", bus.moving, 0);
    rst = 1'b0;

    foreach (directed[i]) applyStimulus(directed[i]);
    for (int i = 0; i < 50; i++) applyStimulus(act_t'($urandom_range(0, 6)));
    repeat (12) applyStimulus(A_IDLE);
    checkDrained();
    checkOutput("idle moving", bus.moving, 0);

    // Park on the left lane, then start a long slide and reset it mid-frame.
    applyStimulus(A_L);
    applyStimulus(A_L);
    repeat (12) applyStimulus(A_IDLE);
    applyStimulus(A_R);
    applyStimulus(A_R);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.vsync = (c < 2);
      if (c == 0) model_tick();
    end
    checkDrained();
    checkOutput("moving before reset", bus.moving, 1);
    mon_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset hoffset", bus.hoffset, 0);
    checkOutput("async reset lane", bus.lane, 1);
    checkOutput("async reset moving", bus.moving, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    m_lane = 1;
    m_hoff = 0;
    hq.delete();
    lq.delete();
    mon_on = 1'b1;

    applyStimulus(A_L);
    repeat (7) applyStimulus(A_IDLE);
    checkDrained();
    checkOutput("final moving", bus.moving, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lane_controller.md
# lane_controller

Player-input stage that feeds the head sprite layer's horizontal offset. It synchronizes and debounces the left/right buttons, tracks which of three lanes the player occupies, and slews the head's signed horizontal offset toward the selected lane once per video frame. Its `hoffset` output drives the head layer directly, replacing the raw button-to-offset mapping at the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles required to accept a button level (10 ms at 100 MHz).
- `LANE_SPACING`, default 100: pixel distance between adjacent lanes; legal range 1..1023.
- `STEP`, default 20: maximum offset change per frame; legal range 1..2047.
- `clk` input 1: system clock (100 MHz); everything runs on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_l` input 1: raw left button, asynchronous.
- `btn_r` input 1: raw right button, asynchronous.
- `vsync` input 1: VGA vertical sync from the timing generator, treated as asynchronous.
- `enable` input 1: when low, button presses are ignored.
- `hoffset` output 12 signed: head layer horizontal offset in pixels.
- `lane` output 2: 0 = LEFT, 1 = CENTER, 2 = RIGHT; 3 never occurs.
- `moving` output 1: high while `hoffset` differs from the current lane target.

## Operation
- Synchronizers: two-flop chain on each of `btn_l`, `btn_r`, `vsync`; all reset to 0.
- Debounce, per button: counter clears whenever the synchronized level equals the debounced level. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1` while still mismatched, the debounced level takes the synchronized value and the counter clears. Any glitch back to the debounced level restarts the count.
- Press pulse: one-cycle pulse on a 0→1 transition of the debounced level. Release generates nothing.
- Frame tick: one-cycle pulse when synchronized `vsync` is 1 and its registered previous value is 0.
- Lane update, applied only when `enable`=1:
  - Left pulse alone: `lane` decrements, saturating at LEFT.
  - Right pulse alone: `lane` increments, saturating at RIGHT.
  - Both pulses in the same cycle: no change.
  - Presses are accepted while sliding; the target moves immediately.
- Target: (`lane`−1)·`LANE_SPACING`, giving −100 / 0 / +100 at defaults.
- Slew arithmetic: diff = target − `hoffset`, computed at 13-bit signed.
  - |diff| ≤ `STEP`: `hoffset` ← target.
  - diff > `STEP`: `hoffset` ← `hoffset`+`STEP`.
  - diff < −`STEP`: `hoffset` ← `hoffset`−`STEP`.
  - The parameter ranges guarantee no 12-bit overflow.
- FSM:
  - IDLE: `hoffset` equals target. Goes to SLIDE in the cycle after a lane change.
  - SLIDE: on each frame tick apply one slew step. Return to IDLE on the tick whose result equals target.
  - If the lane returns to its original value before any tick, SLIDE exits on the next tick with zero movement.
- `moving` = (state == SLIDE).
- `enable` low does not freeze a slide in progress; it only blocks new presses. Debounce keeps running, so a button held across `enable` rising does not generate a press.

## Timing
- Reset values: `hoffset`=0, `lane`=1, `moving`=0, state IDLE; all debounce counters, debounced levels and edge registers 0.
- Reset is asynchronous mid-slide: outputs return to reset values immediately, regardless of `clk`.
- Button press latency:
  - Raw edge to debounced level: 2 + `DEBOUNCE_CYCLES` cycles (±1 for sampling).
  - Press pulse: the cycle after the debounced level changes.
  - `lane`: updates on the edge ending the pulse cycle.
  - `moving`: rises one edge later.
- Frame latency: when `vsync` rises before edge k, the tick is asserted in the cycle after edge k+1. `hoffset` updates at edge k+2 and is then stable for the whole frame.
- A `vsync` already high at reset release may produce one tick 2 cycles later. In IDLE it has no effect.
- Ticks are at most one per frame; a tick coinciding with a lane change uses the pre-change target.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and a fast `vsync` (high 2 cycles every 40).
- Reset check: assert `rst` → `hoffset`=0, `lane`=1, `moving`=0.
- Single right press: hold `btn_r` for 10 cycles → `lane`=2 and `moving`=1. `hoffset` steps 20, 40, 60, 80, 100 on successive frames, and `moving` drops on the tick that reaches 100.
- Bounce rejection: toggle `btn_l` every 2 cycles for 30 cycles, then release → `lane` stays 1, no movement.
- Saturation: three right presses → `lane`=2; `hoffset` ends at 100 and never exceeds it.
- Mid-slide reversal, with `STEP`=30: from 0, press right; after 2 ticks (`hoffset`=60) press left → `lane`=1, `hoffset` goes 30 then 0.
- Blocked and simultaneous input: press with `enable`=0 → no change. Both buttons debouncing in the same cycle → no change. Assert `rst` mid-slide → immediate reset values.
